rr_grant_arbiter: RTL and testbench

- Sequential responder side of the one-hot priority request path: up to N requesters raise `req` bits, and the block issues a registered one-hot grant plus its binary index.
- The grant is held until the owner releases it.
- Priority rotates round-robin after every release so no requester starves.
- A hold timer revokes grants whose owner never releases.
- Sits between requesting masters and a shared resource such as a bus or memory port.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_grant_arbiter.sv | 97 +++++++++
 tb/tb_rr_grant_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: the first set request at or above ptr wins,
// wrapping from N-1 back to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    sel,
    output logic [IDXW-1:0] sel_idx
);

    logic [N-1:0] rot;
    logic [N-1:0] pick;
    int           k;

    // Rotate so ptr lands on bit 0, keep the lowest set bit, then map it back.
    always_comb begin
        rot     = '0;
        pick    = '0;
        sel     = '0;
        sel_idx = '0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = i + int'(ptr);
            if (k >= N) k = k - N;
            rot[i] = req[IDXW'(k)];
        end
        pick = rot & (~rot + N'(1));
        for (int i = 0; i < N; i++) begin
            k = i + int'(ptr);
            if (k >= N) k = k - N;
            if (pick[i]) begin
                sel[IDXW'(k)] = 1'b1;
                sel_idx       = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant that is held until the owner
// releases it, with a hold timer that force-revokes stuck owners.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    arb_state_t        state, state_nxt;
    logic [IDXW-1:0]   ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [N-1:0]      gnt_nxt;
    logic [IDXW-1:0]   gnt_idx_nxt;
    logic              timeout_nxt;
    logic [N-1:0]      sel;
    logic [IDXW-1:0]   sel_idx;
    logic              owner_req;
    logic              hold_max;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .sel     (sel),
        .sel_idx (sel_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= gnt_idx_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // A timeout is flagged only when the hold limit alone ended the grant.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        timeout_nxt = 1'b0;
        owner_req   = req[gnt_idx];
        hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD));
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt   = GRANT;
                    gnt_nxt     = sel;
                    gnt_idx_nxt = sel_idx;
                    hold_nxt    = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_max) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    gnt_idx_nxt = '0;
                    hold_nxt    = '0;
                    ptr_nxt     = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
                    timeout_nxt = hold_max && !done && owner_req;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed stimulus queues expected grants and a
// monitor checks each grant as it appears and when it ends.
module tb_rr_grant_arbiter;

    localparam int N = 8;

    typedef struct {
        int idx;
        int len;
        bit tmo;
        bit bubble;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    exp_t exp_q[$];
    int   total;
    int   bad;

    rr_grant_arbiter #(
        .N        (N),
        .MAX_HOLD (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int idx, input int len, input bit tmo, input bit bubble);
        exp_t e;
        e.idx    = idx;
        e.len    = len;
        e.tmo    = tmo;
        e.bubble = bubble;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    // Monitor: checks grant identity at start, stability while held, length and timeout at end.
    initial begin : monitor
        logic         prev_valid;
        int           len;
        int           idle_cnt;
        logic [N-1:0] cur_gnt;
        exp_t         e;
        prev_valid = 1'b0;
        len        = 0;
        idle_cnt   = 0;
        cur_gnt    = '0;
        forever begin
            @(negedge clk);
            check_output("valid_vs_gnt", int'(gnt_valid), int'(|gnt));
            if (gnt_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_grant", int'(gnt), 0);
                end else begin
                    e = exp_q[0];
                    check_output("grant_idx", int'(gnt_idx), e.idx);
                    check_output("grant_onehot", int'(gnt), 1 << e.idx);
                    if (e.bubble) check_output("bubble_len", idle_cnt, 1);
                end
                cur_gnt = gnt;
                len     = 1;
            end else if (gnt_valid) begin
                len++;
                check_output("grant_stable", int'(gnt), int'(cur_gnt));
            end else if (prev_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_release", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.len > 0) check_output("hold_len", len, e.len);
                    check_output("timeout_flag", int'(timeout), int'(e.tmo));
                end
                idle_cnt = 1;
            end else begin
                idle_cnt++;
            end
            if (timeout && !(prev_valid && !gnt_valid))
                check_output("stray_timeout", int'(timeout), 0);
            prev_valid = gnt_valid;
        end
    end

    initial begin : stimulus
        total   = 0;
        bad     = 0;
        reset_n = 1'b1;
        req     = '0;
        done    = 1'b0;
        #1 reset_n = 1'b0;
        cyc(2);
        check_output("reset_gnt", int'(gnt), 0);
        check_output("reset_idx", int'(gnt_idx), 0);
        check_output("reset_valid", int'(gnt_valid), 0);
        check_output("reset_timeout", int'(timeout), 0);
        reset_n = 1'b1;
        cyc(1);

        // Two requesters, done after three cycles each; ptr then lands on 3.
        req = 8'b0000_0101;
        push(0, 3, 1'b0, 1'b0);
        push(2, 3, 1'b0, 1'b1);
        cyc(3); done = 1'b1;
        cyc(1); done = 1'b0;
        cyc(3); done = 1'b1;
        cyc(1); done = 1'b0; req = 8'b0000_1001;
        push(3, 2, 1'b0, 1'b1);
        cyc(2); req = '0;
        cyc(2);

        // All requesting: full rotation 0..7 and wrap to 0.
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) push(i % 8, 1, 1'b0, i > 0);
        cyc(1);
        for (int i = 0; i < 9; i++) begin
            done = 1'b1;
            cyc(1);
            done = 1'b0;
            if (i == 8) req = '0;
            cyc(1);
        end
        cyc(2);

        // Owner drops its request with no done; next grant proves ptr moved to 6.
        req = 8'b0010_0000;
        push(5, 2, 1'b0, 1'b0);
        push(6, 2, 1'b0, 1'b1);
        cyc(2); req = 8'b0100_0001;
        cyc(3); req = '0;
        cyc(2);

        // Stuck owner: revoked after exactly 16 cycles with a timeout, then re-granted.
        req = 8'b0000_1000;
        push(3, 16, 1'b1, 1'b0);
        push(3, 2, 1'b0, 1'b1);
        cyc(19); done = 1'b1; req = '0;
        cyc(1); done = 1'b0;
        cyc(2);

        // done on the same edge as the hold limit is a normal release.
        req = 8'b0000_1000;
        push(3, 16, 1'b0, 1'b0);
        cyc(16); done = 1'b1;
        cyc(1); done = 1'b0; req = '0;
        cyc(2);

        // Async reset mid-grant of idx 4, then ptr restarts at 0.
        req = 8'b0001_0000;
        push(4, 0, 1'b0, 1'b0);
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_rst_gnt", int'(gnt), 0);
        check_output("async_rst_valid", int'(gnt_valid), 0);
        check_output("async_rst_idx", int'(gnt_idx), 0);
        cyc(1); req = 8'b0001_0001;
        push(0, 1, 1'b0, 1'b0);
        cyc(1); reset_n = 1'b1;
        cyc(1); done = 1'b1;
        cyc(1); done = 1'b0; req = '0;
        cyc(2);

        // Other requesters toggle during a grant; stray done in idle is ignored.
        req = 8'b0000_0100;
        push(2, 4, 1'b0, 1'b0);
        cyc(1); req = 8'b0000_0111;
        cyc(1); req = 8'b1111_1100;
        cyc(1); req = 8'b0000_0110;
        cyc(1); done = 1'b1; req = 8'b0000_0100;
        cyc(1); done = 1'b0; req = '0;
        cyc(2); done = 1'b1;
        cyc(1); done = 1'b0;
        cyc(2); req = 8'b0001_1001;
        push(3, 1, 1'b0, 1'b0);
        cyc(1); done = 1'b1;
        cyc(1); done = 1'b0; req = '0;
        cyc(3);

        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
